// File: rtl/rd_address_decoder_512.sv
`default_nettype none
// ============================================================================
//  Module   : rd_address_decoder_512
//  Purpose  : AXI4 read-side line fetcher for the 512-bit frame buffer.
//             Fetches one video line per request as 32-beat INCR bursts,
//             stores it in a ping-pong line buffer and serves 4-byte pixel
//             groups to the display pipeline with one cycle of latency.
//  Revision : 1.0  initial release
// ============================================================================
module rd_address_decoder_512 (
  input  logic         p_clk,
  input  logic         rstn,
  // window configuration
  input  logic [11:0]  x_win,
  input  logic [11:0]  x_start,
  input  logic [11:0]  y_win,
  input  logic [11:0]  y_start,
  // line request interface
  input  logic [2:0]   in_frame_cnt,
  input  logic         in_line_req,
  input  logic [11:0]  in_line_y,
  output logic         out_line_done,
  output logic         out_req_drop,
  output logic         out_rd_err,
  // AXI4 read address channel
  output logic         out_rd_avalid,
  input  logic         in_rd_aready,
  output logic [31:0]  out_rd_addr,
  output logic [7:0]   out_rd_len,
  // AXI4 read data channel
  input  logic         in_rd_valid,
  input  logic         in_rd_last,
  input  logic [511:0] in_rd_data,
  output logic         out_rd_ready,
  // pixel read interface
  input  logic         in_rd_en,
  input  logic [11:0]  in_x_rd,
  input  logic [11:0]  in_y_rd,
  output logic [7:0]   out_rd_00,
  output logic [7:0]   out_rd_01,
  output logic [7:0]   out_rd_10,
  output logic [7:0]   out_rd_11,
  output logic         out_rd_valid
);

  localparam int         X_WID     = 12;
  localparam int         Y_WID     = 12;
  localparam int         BURST_LEN = 32;
  localparam logic [4:0] LAST_BEAT = 5'(BURST_LEN - 1);
  localparam logic [7:0] ARLEN     = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_ADDR = 2'd1,
    READ_DATA = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t             r_state;
  logic [Y_WID-1:0]   r_y_l;
  logic [2:0]         r_frame_l;
  logic               r_burst_idx;
  logic [4:0]         r_beat;
  logic               r_pend;
  logic [Y_WID-1:0]   r_pend_y;
  logic [2:0]         r_pend_frame;
  logic               r_avalid;
  logic               r_ready;
  logic               r_line_done;
  logic               r_req_drop;
  logic               r_rd_err;
  logic [31:0]        r_pix;
  logic               r_pix_valid;

  // 2 halves x 2 bursts x 32 beats of 512 bits
  logic [511:0]       r_mem [0:127];

  logic               w_beat_acc;
  logic               w_last_beat;
  logic               w_more_bursts;
  logic [X_WID-1:0]   w_x_nom;
  logic [Y_WID-1:0]   w_y_nom;
  logic [6:0]         w_raddr;
  logic [8:0]         w_word_lsb;
  logic               w_unused;

  assign w_beat_acc    = (r_state == READ_DATA) && in_rd_valid && r_ready;
  assign w_last_beat   = (r_beat == LAST_BEAT);
  // a line wider than 2047 pixels needs a second 2 KiB burst
  assign w_more_bursts = x_win[11] && !r_burst_idx;

  assign w_x_nom    = in_x_rd - x_start;
  assign w_y_nom    = in_y_rd - y_start;
  assign w_raddr    = {w_y_nom[0], w_x_nom[11:6]};
  assign w_word_lsb = {w_x_nom[5:2], 5'b0};

  // y_win only mirrors the write side's register set
  assign w_unused = ^{y_win, x_win[10:0], w_x_nom[1:0], w_y_nom[11:1]};

  // Request queueing and AXI read sequencing
  always_ff @(posedge p_clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_y_l        <= '0;
      r_frame_l    <= '0;
      r_burst_idx  <= 1'b0;
      r_beat       <= '0;
      r_pend       <= 1'b0;
      r_pend_y     <= '0;
      r_pend_frame <= '0;
      r_avalid     <= 1'b0;
      r_ready      <= 1'b0;
      r_line_done  <= 1'b0;
      r_req_drop   <= 1'b0;
      r_rd_err     <= 1'b0;
    end else begin
      r_line_done <= 1'b0;
      r_req_drop  <= 1'b0;

      // busy: park one request, drop anything beyond that
      if (in_line_req && (r_state != IDLE)) begin
        if (r_pend) begin
          r_req_drop <= 1'b1;
        end else begin
          r_pend       <= 1'b1;
          r_pend_y     <= in_line_y;
          r_pend_frame <= in_frame_cnt;
        end
      end

      case (r_state)
        IDLE: begin
          if (r_pend) begin
            // older parked request goes first; a new one takes its slot
            r_y_l       <= r_pend_y;
            r_frame_l   <= r_pend_frame;
            r_burst_idx <= 1'b0;
            r_avalid    <= 1'b1;
            r_state     <= READ_ADDR;
            if (in_line_req) begin
              r_pend_y     <= in_line_y;
              r_pend_frame <= in_frame_cnt;
            end else begin
              r_pend <= 1'b0;
            end
          end else if (in_line_req) begin
            r_y_l       <= in_line_y;
            r_frame_l   <= in_frame_cnt;
            r_burst_idx <= 1'b0;
            r_avalid    <= 1'b1;
            r_state     <= READ_ADDR;
          end
        end
        READ_ADDR: begin
          if (in_rd_aready) begin
            r_avalid <= 1'b0;
            r_ready  <= 1'b1;
            r_beat   <= '0;
            r_state  <= READ_DATA;
          end
        end
        READ_DATA: begin
          if (w_beat_acc) begin
            r_beat <= r_beat + 5'd1;
            // RLAST is only checked, the beat counter ends the burst
            if (in_rd_last != w_last_beat) begin
              r_rd_err <= 1'b1;
            end
            if (w_last_beat) begin
              r_ready <= 1'b0;
              if (w_more_bursts) begin
                r_burst_idx <= 1'b1;
                r_avalid    <= 1'b1;
                r_state     <= READ_ADDR;
              end else begin
                r_line_done <= 1'b1;
                r_state     <= DONE;
              end
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Line buffer fill; contents are not reset
  always_ff @(posedge p_clk) begin
    if (w_beat_acc) begin
      r_mem[{r_y_l[0], r_burst_idx, r_beat}] <= in_rd_data;
    end
  end

  // Pixel fetch: one-cycle latency, bytes hold while the strobe is low
  always_ff @(posedge p_clk) begin
    if (!rstn) begin
      r_pix       <= '0;
      r_pix_valid <= 1'b0;
    end else begin
      r_pix_valid <= in_rd_en;
      if (in_rd_en) begin
        r_pix <= r_mem[w_raddr][w_word_lsb +: 32];
      end
    end
  end

  assign out_rd_avalid = r_avalid;
  assign out_rd_addr   = {5'b0, r_frame_l, r_y_l, r_burst_idx, 11'b0};
  assign out_rd_len    = ARLEN;
  assign out_rd_ready  = r_ready;
  assign out_line_done = r_line_done;
  assign out_req_drop  = r_req_drop;
  assign out_rd_err    = r_rd_err;
  assign out_rd_00     = r_pix[7:0];
  assign out_rd_01     = r_pix[15:8];
  assign out_rd_10     = r_pix[23:16];
  assign out_rd_11     = r_pix[31:24];
  assign out_rd_valid  = r_pix_valid;

endmodule
`default_nettype wire

// File: tb/tb_rd_address_decoder_512.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rd_address_decoder_512
//  Purpose  : Self-checking bench for rd_address_decoder_512 with a random
//             AXI read slave and a byte-addressed line model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rd_address_decoder_512;

  logic         p_clk = 1'b0;
  logic         rstn = 1'b0;
  logic [11:0]  x_win, x_start, y_win, y_start;
  logic [2:0]   in_frame_cnt;
  logic         in_line_req;
  logic [11:0]  in_line_y;
  logic         out_line_done, out_req_drop, out_rd_err;
  logic         out_rd_avalid, in_rd_aready;
  logic [31:0]  out_rd_addr;
  logic [7:0]   out_rd_len;
  logic         in_rd_valid, in_rd_last, out_rd_ready;
  logic [511:0] in_rd_data;
  logic         in_rd_en;
  logic [11:0]  in_x_rd, in_y_rd;
  logic [7:0]   out_rd_00, out_rd_01, out_rd_10, out_rd_11;
  logic         out_rd_valid;

  always #5 p_clk = ~p_clk;

  rd_address_decoder_512 dut (
    .p_clk(p_clk), .rstn(rstn),
    .x_win(x_win), .x_start(x_start), .y_win(y_win), .y_start(y_start),
    .in_frame_cnt(in_frame_cnt), .in_line_req(in_line_req), .in_line_y(in_line_y),
    .out_line_done(out_line_done), .out_req_drop(out_req_drop), .out_rd_err(out_rd_err),
    .out_rd_avalid(out_rd_avalid), .in_rd_aready(in_rd_aready),
    .out_rd_addr(out_rd_addr), .out_rd_len(out_rd_len),
    .in_rd_valid(in_rd_valid), .in_rd_last(in_rd_last), .in_rd_data(in_rd_data),
    .out_rd_ready(out_rd_ready),
    .in_rd_en(in_rd_en), .in_x_rd(in_x_rd), .in_y_rd(in_y_rd),
    .out_rd_00(out_rd_00), .out_rd_01(out_rd_01), .out_rd_10(out_rd_10),
    .out_rd_11(out_rd_11), .out_rd_valid(out_rd_valid)
  );

  int errors = 0;
  int checks = 0;

  // slave behaviour knobs
  int aready_delay = 0;
  int rvalid_pct = 100;
  int rlast_err_beat = -1;

  // reference: each ping-pong half holds one line as plain bytes
  logic [7:0]  exp_mem [0:1][0:4095];
  logic [31:0] ar_log [$];
  logic [31:0] ar_q [$];
  int beat_total = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  int stab_viol = 0;

  function automatic logic [31:0] exp_addr(input logic [2:0] f, input logic [11:0] y, input logic b);
    return {5'b0, f, y, b, 11'b0};
  endfunction

  function automatic logic [31:0] exp_pix(input logic [11:0] xn, input logic [11:0] yn);
    logic [31:0] r;
    int base;
    base = (int'(xn) / 4) * 4;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = exp_mem[yn[0]][base + k];
    return r;
  endfunction

  // AXI read slave plus event monitor, all on the falling edge
  initial begin : axi_slave
    bit          active;
    bit          holding;
    bit          prev_avalid;
    int          beat;
    int          ar_wait;
    int          base;
    logic [31:0] cur_addr;
    logic [31:0] prev_addr;
    active = 0; holding = 0; prev_avalid = 0; beat = 0; ar_wait = 0;
    cur_addr = '0; prev_addr = '0;
    in_rd_aready = 1'b0; in_rd_valid = 1'b0; in_rd_last = 1'b0; in_rd_data = '0;
    forever begin
      @(negedge p_clk);
      if (!rstn) begin
        active = 0; holding = 0; prev_avalid = 0; ar_wait = 0;
        ar_q.delete();
        in_rd_aready = 1'b0; in_rd_valid = 1'b0; in_rd_last = 1'b0;
        continue;
      end
      if (out_line_done) done_cnt++;
      if (out_req_drop) drop_cnt++;
      if (prev_avalid && !in_rd_aready && (!out_rd_avalid || out_rd_addr != prev_addr)) stab_viol++;
      prev_avalid = out_rd_avalid;
      prev_addr = out_rd_addr;
      // R channel
      if (!active && ar_q.size() > 0) begin
        cur_addr = ar_q.pop_front();
        active = 1; beat = 0; holding = 0;
      end
      if (active) begin
        if (!holding) begin
          if (int'($urandom_range(99)) < rvalid_pct) begin
            in_rd_valid = 1'b1;
            for (int w = 0; w < 16; w++) in_rd_data[w*32 +: 32] = $urandom();
            in_rd_last = (beat == 31) || (beat == rlast_err_beat);
          end else begin
            in_rd_valid = 1'b0;
            in_rd_last = 1'b0;
          end
        end
        if (in_rd_valid && out_rd_ready) begin
          base = int'(cur_addr[11]) * 2048 + beat * 64;
          for (int b = 0; b < 64; b++) exp_mem[cur_addr[12]][base + b] = in_rd_data[b*8 +: 8];
          beat_total++;
          beat++;
          holding = 0;
          if (beat == 32) active = 0;
        end else begin
          holding = in_rd_valid;
        end
      end else begin
        in_rd_valid = 1'b0;
        in_rd_last = 1'b0;
      end
      // AR channel
      if (out_rd_avalid) begin
        if (ar_wait < aready_delay) begin
          in_rd_aready = 1'b0;
          ar_wait++;
        end else begin
          in_rd_aready = 1'b1;
          ar_q.push_back(out_rd_addr);
          ar_log.push_back(out_rd_addr);
          ar_wait = 0;
        end
      end else begin
        in_rd_aready = 1'b0;
        ar_wait = 0;
      end
    end
  end

  task automatic req(input logic [11:0] y, input logic [2:0] f);
    in_line_req = 1'b1; in_line_y = y; in_frame_cnt = f;
    @(negedge p_clk);
    in_line_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt >= target) begin ok = 1; break; end
      @(negedge p_clk);
    end
  endtask

  task automatic pix_read(input logic [11:0] x, input logic [11:0] y, output logic [31:0] got, output logic vld);
    in_rd_en = 1'b1; in_x_rd = x; in_y_rd = y;
    @(negedge p_clk);
    got = {out_rd_11, out_rd_10, out_rd_01, out_rd_00};
    vld = out_rd_valid;
    in_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge p_clk);
    checks++; if (out_rd_avalid !== 1'b0) begin errors++; $display("FAIL reset_avalid: got %b exp 0", out_rd_avalid); end
    checks++; if (out_rd_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", out_rd_addr); end
    checks++; if (out_rd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", out_rd_ready); end
    checks++; if (out_line_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", out_line_done); end
    checks++; if (out_req_drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b exp 0", out_req_drop); end
    checks++; if (out_rd_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", out_rd_err); end
    checks++; if (out_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_pvalid: got %b exp 0", out_rd_valid); end
    checks++; if ({out_rd_11, out_rd_10, out_rd_01, out_rd_00} !== 32'h0) begin errors++; $display("FAIL reset_pix: got %h exp 0", {out_rd_11, out_rd_10, out_rd_01, out_rd_00}); end
    checks++; if (out_rd_len !== 8'd31) begin errors++; $display("FAIL reset_len: got %0d exp 31", out_rd_len); end
    rstn = 1'b1;
    @(negedge p_clk);
  endtask

  task automatic test_single_burst();
    int a0, b0, d0;
    bit ok;
    logic [31:0] got, hold;
    logic vld;
    x_win = 12'd1920; aready_delay = 0; rvalid_pct = 100; rlast_err_beat = -1;
    a0 = ar_log.size(); b0 = beat_total; d0 = done_cnt;
    req(12'd5, 3'd2);
    wait_done(d0 + 1, 300, ok);
    repeat (3) @(negedge p_clk);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got done=%0d exp %0d", done_cnt - d0, 1); end
    checks++; if (ar_log.size() - a0 != 1) begin errors++; $display("FAIL single_ar_count: got %0d exp 1", ar_log.size() - a0); end
    checks++; if (ar_log.size() > a0 && ar_log[a0] !== exp_addr(3'd2, 12'd5, 1'b0)) begin errors++; $display("FAIL single_addr: got %h exp %h", ar_log[a0], exp_addr(3'd2, 12'd5, 1'b0)); end
    checks++; if (beat_total - b0 != 32) begin errors++; $display("FAIL single_beats: got %0d exp 32", beat_total - b0); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done: got %0d exp 1", done_cnt - d0); end
    checks++; if (out_rd_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b exp 0", out_rd_err); end
    x_start = 12'($urandom_range(0, 4095)); y_start = 12'($urandom_range(0, 4095));
    pix_read(x_start + 12'h104, y_start + 12'd5, got, vld);
    checks++; if (got !== exp_pix(12'h104, 12'd5)) begin errors++; $display("FAIL single_pix: got %h exp %h", got, exp_pix(12'h104, 12'd5)); end
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL single_pvalid: got %b exp 1", vld); end
    hold = got;
    in_x_rd = x_start + 12'h200;
    @(negedge p_clk);
    checks++; if (out_rd_valid !== 1'b0) begin errors++; $display("FAIL hold_pvalid: got %b exp 0", out_rd_valid); end
    checks++; if ({out_rd_11, out_rd_10, out_rd_01, out_rd_00} !== hold) begin errors++; $display("FAIL hold_pix: got %h exp %h", {out_rd_11, out_rd_10, out_rd_01, out_rd_00}, hold); end
  endtask

  task automatic test_two_bursts();
    int a0, b0, d0;
    bit ok;
    logic [2:0] f;
    logic [11:0] xn;
    logic [31:0] got;
    logic vld;
    x_win = 12'd2048; aready_delay = 0; rvalid_pct = 100; rlast_err_beat = -1;
    f = 3'($urandom_range(0, 7));
    a0 = ar_log.size(); b0 = beat_total; d0 = done_cnt;
    req(12'd7, f);
    wait_done(d0 + 1, 400, ok);
    repeat (3) @(negedge p_clk);
    checks++; if (!ok) begin errors++; $display("FAIL two_timeout: got done=%0d exp 1", done_cnt - d0); end
    checks++; if (ar_log.size() - a0 != 2) begin errors++; $display("FAIL two_ar_count: got %0d exp 2", ar_log.size() - a0); end
    if (ar_log.size() - a0 >= 2) begin
      checks++; if (ar_log[a0] !== exp_addr(f, 12'd7, 1'b0)) begin errors++; $display("FAIL two_addr0: got %h exp %h", ar_log[a0], exp_addr(f, 12'd7, 1'b0)); end
      checks++; if (ar_log[a0+1] !== ar_log[a0] + 32'h800) begin errors++; $display("FAIL two_addr1: got %h exp %h", ar_log[a0+1], ar_log[a0] + 32'h800); end
    end
    checks++; if (beat_total - b0 != 64) begin errors++; $display("FAIL two_beats: got %0d exp 64", beat_total - b0); end
    for (int i = 0; i < 16; i++) begin
      xn = (i == 0) ? 12'd0 : (i == 1) ? 12'hFFC : 12'($urandom_range(0, 4095));
      pix_read(x_start + xn, y_start + 12'd7, got, vld);
      checks++; if (got !== exp_pix(xn, 12'd7) || vld !== 1'b1) begin errors++; $display("FAIL two_pix x=%h: got %h/%b exp %h/1", xn, got, vld, exp_pix(xn, 12'd7)); end
    end
  endtask

  task automatic test_backpressure();
    int a0, b0, d0, s0;
    bit ok;
    logic [11:0] y, xn;
    logic [31:0] got;
    logic vld;
    x_win = 12'($urandom_range(2048, 4095)); aready_delay = 10; rvalid_pct = 50; rlast_err_beat = -1;
    y = 12'($urandom_range(0, 2047) * 2);
    a0 = ar_log.size(); b0 = beat_total; d0 = done_cnt; s0 = stab_viol;
    req(y, 3'd1);
    wait_done(d0 + 1, 2000, ok);
    repeat (20) @(negedge p_clk);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got done=%0d exp 1", done_cnt - d0); end
    checks++; if (stab_viol - s0 != 0) begin errors++; $display("FAIL bp_stable: got %0d violations exp 0", stab_viol - s0); end
    checks++; if (ar_log.size() - a0 != 2) begin errors++; $display("FAIL bp_ar_count: got %0d exp 2", ar_log.size() - a0); end
    checks++; if (beat_total - b0 != 64) begin errors++; $display("FAIL bp_beats: got %0d exp 64", beat_total - b0); end
    checks++; if (out_rd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_idle: got %b exp 0", out_rd_ready); end
    for (int i = 0; i < 8; i++) begin
      xn = 12'($urandom_range(0, 4095));
      pix_read(x_start + xn, y_start + y, got, vld);
      checks++; if (got !== exp_pix(xn, y)) begin errors++; $display("FAIL bp_pix x=%h: got %h exp %h", xn, got, exp_pix(xn, y)); end
    end
    aready_delay = 0; rvalid_pct = 100;
  endtask

  task automatic test_rlast_err();
    int b0, d0;
    bit ok;
    x_win = 12'd1000; rlast_err_beat = 15;
    b0 = beat_total; d0 = done_cnt;
    req(12'd3, 3'd0);
    wait_done(d0 + 1, 300, ok);
    @(negedge p_clk);
    checks++; if (!ok) begin errors++; $display("FAIL rlast_timeout: got done=%0d exp 1", done_cnt - d0); end
    checks++; if (beat_total - b0 != 32) begin errors++; $display("FAIL rlast_beats: got %0d exp 32", beat_total - b0); end
    checks++; if (out_rd_err !== 1'b1) begin errors++; $display("FAIL rlast_err_set: got %b exp 1", out_rd_err); end
    rlast_err_beat = -1;
    d0 = done_cnt;
    req(12'd4, 3'd0);
    wait_done(d0 + 1, 300, ok);
    @(negedge p_clk);
    checks++; if (!ok) begin errors++; $display("FAIL rlast2_timeout: got done=%0d exp 1", done_cnt - d0); end
    checks++; if (out_rd_err !== 1'b1) begin errors++; $display("FAIL rlast_err_sticky: got %b exp 1", out_rd_err); end
  endtask

  task automatic test_requests();
    int a0, d0, r0;
    bit ok;
    x_win = 12'd100; aready_delay = 2; rvalid_pct = 100; rlast_err_beat = -1;
    a0 = ar_log.size(); d0 = done_cnt; r0 = drop_cnt;
    req(12'd10, 3'd1);
    repeat (3) @(negedge p_clk);
    req(12'd11, 3'd3);
    req(12'd12, 3'd5);
    // land a new request on the IDLE cycle where the parked one is taken
    for (int i = 0; i < 300; i++) begin
      if (out_line_done) break;
      @(negedge p_clk);
    end
    @(negedge p_clk);
    req(12'd13, 3'd6);
    wait_done(d0 + 3, 600, ok);
    repeat (50) @(negedge p_clk);
    checks++; if (!ok) begin errors++; $display("FAIL req_timeout: got done=%0d exp 3", done_cnt - d0); end
    checks++; if (drop_cnt - r0 != 1) begin errors++; $display("FAIL req_drop: got %0d exp 1", drop_cnt - r0); end
    checks++; if (done_cnt - d0 != 3) begin errors++; $display("FAIL req_done: got %0d exp 3", done_cnt - d0); end
    checks++; if (ar_log.size() - a0 != 3) begin errors++; $display("FAIL req_ar_count: got %0d exp 3", ar_log.size() - a0); end
    if (ar_log.size() - a0 >= 3) begin
      checks++; if (ar_log[a0] !== exp_addr(3'd1, 12'd10, 1'b0)) begin errors++; $display("FAIL req_addr_a: got %h exp %h", ar_log[a0], exp_addr(3'd1, 12'd10, 1'b0)); end
      checks++; if (ar_log[a0+1] !== exp_addr(3'd3, 12'd11, 1'b0)) begin errors++; $display("FAIL req_addr_b: got %h exp %h", ar_log[a0+1], exp_addr(3'd3, 12'd11, 1'b0)); end
      checks++; if (ar_log[a0+2] !== exp_addr(3'd6, 12'd13, 1'b0)) begin errors++; $display("FAIL req_addr_d: got %h exp %h", ar_log[a0+2], exp_addr(3'd6, 12'd13, 1'b0)); end
    end
    aready_delay = 0;
  endtask

  task automatic test_reset_mid();
    int a0, b0, d0;
    bit ok;
    x_win = 12'd1920; aready_delay = 0; rvalid_pct = 100; rlast_err_beat = -1;
    b0 = beat_total;
    req(12'd20, 3'd0);
    for (int i = 0; i < 200; i++) begin
      if (beat_total - b0 >= 10) break;
      @(negedge p_clk);
    end
    checks++; if (out_rd_ready !== 1'b1) begin errors++; $display("FAIL mid_in_data: got ready=%b exp 1", out_rd_ready); end
    rstn = 1'b0;
    @(negedge p_clk);
    checks++; if (out_rd_avalid !== 1'b0 || out_rd_ready !== 1'b0) begin errors++; $display("FAIL mid_axi: got avalid=%b ready=%b exp 0/0", out_rd_avalid, out_rd_ready); end
    checks++; if (out_rd_addr !== 32'h0) begin errors++; $display("FAIL mid_addr: got %h exp 0", out_rd_addr); end
    checks++; if (out_rd_err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b exp 0", out_rd_err); end
    checks++; if (out_line_done !== 1'b0 || out_req_drop !== 1'b0 || out_rd_valid !== 1'b0) begin errors++; $display("FAIL mid_pulses: got done=%b drop=%b pv=%b exp 0", out_line_done, out_req_drop, out_rd_valid); end
    checks++; if ({out_rd_11, out_rd_10, out_rd_01, out_rd_00} !== 32'h0 || out_rd_len !== 8'd31) begin errors++; $display("FAIL mid_pix_len: got %h/%0d exp 0/31", {out_rd_11, out_rd_10, out_rd_01, out_rd_00}, out_rd_len); end
    @(negedge p_clk);
    rstn = 1'b1;
    @(negedge p_clk);
    a0 = ar_log.size(); b0 = beat_total; d0 = done_cnt;
    req(12'd21, 3'd4);
    wait_done(d0 + 1, 300, ok);
    repeat (3) @(negedge p_clk);
    checks++; if (!ok || done_cnt - d0 != 1) begin errors++; $display("FAIL mid_restart_done: got %0d exp 1", done_cnt - d0); end
    checks++; if (ar_log.size() - a0 != 1 || ar_log[ar_log.size()-1] !== exp_addr(3'd4, 12'd21, 1'b0)) begin errors++; $display("FAIL mid_restart_addr: got %h exp %h", ar_log[ar_log.size()-1], exp_addr(3'd4, 12'd21, 1'b0)); end
    checks++; if (beat_total - b0 != 32) begin errors++; $display("FAIL mid_restart_beats: got %0d exp 32", beat_total - b0); end
  endtask

  initial begin
    x_win = 12'd1920; x_start = 12'd0; y_win = 12'd1080; y_start = 12'd0;
    in_frame_cnt = 3'd0; in_line_req = 1'b0; in_line_y = 12'd0;
    in_rd_en = 1'b0; in_x_rd = 12'd0; in_y_rd = 12'd0;
    test_reset();
    test_single_burst();
    test_two_bursts();
    test_backpressure();
    test_rlast_err();
    test_requests();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
